pong_game_ctrl: RTL and testbench

Frame-rate game controller for VGA Pong. It owns the game state machine, paddle position, ball position and velocity, score and lives. It advances once per video frame on a one-cycle tick from the VGA timing block, and its position/state outputs drive the pixel generator. Debounced button levels are inputs; the block does not debounce.

---
 rtl/pong_game_ctrl_pkg.sv | 27 ++
 rtl/pong_game_ctrl_paddle_ctrl.sv | 41 ++++
 rtl/pong_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// pong_game_ctrl_pkg: shared FSM encodings, default geometry and helpers for the Pong controller and pixel generator.
package pong_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_OVER  = 3'd3
    } state_t;

    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_BALL_SPEED   = 2;
    localparam int DEF_PADDLE_X     = 616;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_STEP  = 4;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_LIVES        = 3;

    // Top/left coordinate that centres an object of length size inside span.
    function automatic logic [9:0] center(input int span, input int size);
        return 10'((span - size) / 2);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_paddle_ctrl.sv
// pong_paddle_ctrl: paddle top-line register with per-frame step and screen clamp.
//   i_clock, i_reset (sync, active-low), i_tick (frame tick), i_move_en (SERVE|PLAY),
//   i_recenter (restart request), i_up/i_down (button levels), o_paddle_y (paddle top line).
module pong_paddle_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_move_en,
    input  logic       i_recenter,
    input  logic       i_up,
    input  logic       i_down,
    output logic [9:0] o_paddle_y
);
    localparam logic [10:0] STEP  = 11'(PADDLE_STEP);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - PADDLE_H);
    localparam logic [9:0]  Y_CTR = center(V_ACTIVE, PADDLE_H);

    // One extra bit so a step past either edge is visible before clamping.
    logic [10:0] py;
    logic [9:0]  y_up, y_dn;

    always_comb begin
        py   = {1'b0, o_paddle_y};
        y_up = (py < STEP) ? 10'd0 : 10'(py - STEP);
        y_dn = (py + STEP > Y_MAX) ? 10'(Y_MAX) : 10'(py + STEP);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset || (i_tick && i_recenter))
            o_paddle_y <= Y_CTR;
        else if (i_tick && i_move_en && (i_up ^ i_down))
            o_paddle_y <= i_up ? y_up : y_dn;
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate Pong controller owning FSM, ball motion/collisions, score and lives.
//   i_clock, i_reset (sync, active-low), i_frame_tick (one pulse per frame), i_up/i_down (buttons);
//   o_ball_x/o_ball_y (ball top-left), o_paddle_y, o_score (saturating hits), o_lives,
//   o_state (FSM encoding), o_game_over (high in OVER).
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int PADDLE_X     = DEF_PADDLE_X,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_STEP  = DEF_PADDLE_STEP,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int LIVES        = DEF_LIVES
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_frame_tick,
    input  logic       i_up,
    input  logic       i_down,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic [9:0] o_paddle_y,
    output logic [7:0] o_score,
    output logic [1:0] o_lives,
    output logic [2:0] o_state,
    output logic       o_game_over
);
    localparam logic signed [10:0] SPD   = 11'(BALL_SPEED);
    localparam logic signed [10:0] BS    = 11'(BALL_SIZE);
    localparam logic signed [10:0] PX    = 11'(PADDLE_X);
    localparam logic signed [10:0] PH    = 11'(PADDLE_H);
    localparam logic signed [10:0] HA    = 11'(H_ACTIVE);
    localparam logic signed [10:0] Y_LIM = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]         X0    = center(H_ACTIVE, BALL_SIZE);
    localparam logic [9:0]         Y0    = center(V_ACTIVE, BALL_SIZE);
    localparam int                 CW    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0]      SERVE_CNT = CW'(SERVE_FRAMES);
    localparam logic [1:0]         LIVES0    = 2'(LIVES);

    state_t         state;
    logic [9:0]     ball_x, ball_y, paddle_y;
    logic           dx_neg, dy_neg;
    logic [CW-1:0]  serve_cnt;

    logic signed [10:0] bx, by, py, nx, ny, x_next, y_next;
    logic top_hit, bot_hit, wall_hit, paddle_hit, miss, dx_next, dy_next;

    // Candidate next position and all collision decisions for a PLAY tick,
    // judged against the paddle position before this tick's move.
    always_comb begin
        bx         = signed'({1'b0, ball_x});
        by         = signed'({1'b0, ball_y});
        py         = signed'({1'b0, paddle_y});
        nx         = bx + (dx_neg ? -SPD : SPD);
        ny         = by + (dy_neg ? -SPD : SPD);
        top_hit    = ny <= 11'sd0;
        bot_hit    = ny >= Y_LIM;
        wall_hit   = nx <= 11'sd0;
        paddle_hit = !dx_neg && (bx + BS <= PX) && (nx + BS > PX) && (ny + BS > py) && (ny < py + PH);
        miss       = nx + BS >= HA;
        y_next     = top_hit ? 11'sd0 : bot_hit ? Y_LIM : ny;
        dy_next    = top_hit ? 1'b0 : bot_hit ? 1'b1 : dy_neg;
        x_next     = wall_hit ? 11'sd0 : paddle_hit ? PX - BS : nx;
        dx_next    = wall_hit ? 1'b0 : paddle_hit ? 1'b1 : dx_neg;
    end

    pong_paddle_ctrl #(
        .V_ACTIVE    (V_ACTIVE),
        .PADDLE_H    (PADDLE_H),
        .PADDLE_STEP (PADDLE_STEP)
    ) u_paddle (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_tick     (i_frame_tick),
        .i_move_en  (state == ST_SERVE || state == ST_PLAY),
        .i_recenter (state == ST_OVER && i_up && i_down),
        .i_up       (i_up),
        .i_down     (i_down),
        .o_paddle_y (paddle_y)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            ball_x      <= X0;
            ball_y      <= Y0;
            dx_neg      <= 1'b1;
            dy_neg      <= 1'b0;
            o_score     <= 8'd0;
            o_lives     <= LIVES0;
            serve_cnt   <= '0;
            o_game_over <= 1'b0;
        end else if (i_frame_tick) begin
            case (state)
                ST_IDLE: begin
                    if (i_up | i_down) begin
                        state     <= ST_SERVE;
                        serve_cnt <= SERVE_CNT;
                    end
                end
                ST_SERVE: begin
                    serve_cnt <= serve_cnt - 1'b1;
                    if (serve_cnt == CW'(1))
                        state <= ST_PLAY;
                end
                ST_PLAY: begin
                    ball_y <= 10'(y_next);
                    dy_neg <= dy_next;
                    if (miss) begin
                        // Recentre overrides the vertical update; dy keeps its bounce result.
                        o_lives <= o_lives - 2'd1;
                        ball_x  <= X0;
                        ball_y  <= Y0;
                        dx_neg  <= 1'b1;
                        if (o_lives == 2'd1) begin
                            state       <= ST_OVER;
                            o_game_over <= 1'b1;
                        end else begin
                            state     <= ST_SERVE;
                            serve_cnt <= SERVE_CNT;
                        end
                    end else begin
                        ball_x <= 10'(x_next);
                        dx_neg <= dx_next;
                        if (paddle_hit && o_score != 8'hff)
                            o_score <= o_score + 8'd1;
                    end
                end
                ST_OVER: begin
                    if (i_up & i_down) begin
                        state       <= ST_IDLE;
                        o_game_over <= 1'b0;
                        o_score     <= 8'd0;
                        o_lives     <= LIVES0;
                        ball_x      <= X0;
                        ball_y      <= Y0;
                        dx_neg      <= 1'b1;
                        dy_neg      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ball_x   = ball_x;
    assign o_ball_y   = ball_y;
    assign o_paddle_y = paddle_y;
    assign o_state    = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl.
module tb_pong_game_ctrl;
    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_frame_tick = 1'b0;
    logic       i_up = 1'b0;
    logic       i_down = 1'b0;
    logic [9:0] o_ball_x, o_ball_y, o_paddle_y;
    logic [7:0] o_score;
    logic [1:0] o_lives;
    logic [2:0] o_state;
    logic       o_game_over;

    int checks = 0;
    int failures = 0;

    // Field order: ball_x, ball_y, paddle_y, score, lives, state, game_over.
    logic [43:0] got, e;
    assign got = {o_ball_x, o_ball_y, o_paddle_y, o_score, o_lives, o_state, o_game_over};

    always #5 i_clock = ~i_clock;

    pong_game_ctrl dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_frame_tick (i_frame_tick),
        .i_up         (i_up),
        .i_down       (i_down),
        .o_ball_x     (o_ball_x),
        .o_ball_y     (o_ball_y),
        .o_paddle_y   (o_paddle_y),
        .o_score      (o_score),
        .o_lives      (o_lives),
        .o_state      (o_state),
        .o_game_over  (o_game_over)
    );

    function automatic logic [43:0] ev(input int x, input int y, input int p, input int s,
                                       input int l, input int st, input int go);
        return {10'(x), 10'(y), 10'(p), 8'(s), 2'(l), 3'(st), 1'(go)};
    endfunction

    // One tick pulse covering exactly one rising edge, then two idle cycles.
    task automatic tick(input int n);
        repeat (n) begin
            i_frame_tick = 1'b1;
            @(negedge i_clock);
            i_frame_tick = 1'b0;
            @(negedge i_clock);
            @(negedge i_clock);
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b0; i_frame_tick = 1'b1; i_up = 1'b1;
        @(negedge i_clock); @(negedge i_clock);
        i_frame_tick = 1'b0; i_up = 1'b0;
        e = ev(316, 236, 208, 0, 3, 0, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL reset_values got=%h exp=%h", got, e); end
        i_reset = 1'b1;
        @(negedge i_clock);
        checks++;
        if (got !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", got, e); end
    endtask

    task automatic test_idle;
        tick(5);
        e = ev(316, 236, 208, 0, 3, 0, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL idle_5_ticks got=%h exp=%h", got, e); end
    endtask

    task automatic test_serve;
        i_up = 1'b1; tick(1);
        e = ev(316, 236, 208, 0, 3, 1, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL serve_enter got=%h exp=%h", got, e); end
        i_down = 1'b1; tick(58);
        checks++;
        if (got !== e) begin failures++; $display("FAIL serve_both_buttons got=%h exp=%h", got, e); end
        i_up = 1'b0; i_down = 1'b0; tick(1);
        checks++;
        if (got !== e) begin failures++; $display("FAIL serve_tick59 got=%h exp=%h", got, e); end
        tick(1);
        e = ev(316, 236, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL serve_to_play got=%h exp=%h", got, e); end
        tick(1);
        e = ev(314, 238, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL first_move got=%h exp=%h", got, e); end
    endtask

    task automatic test_bounce;
        tick(116);
        e = ev(82, 470, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL pre_bottom got=%h exp=%h", got, e); end
        tick(1);
        e = ev(80, 472, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL bottom_clamp got=%h exp=%h", got, e); end
        tick(1);
        e = ev(78, 470, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL bottom_rebound got=%h exp=%h", got, e); end
        tick(38);
        e = ev(2, 394, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL pre_wall got=%h exp=%h", got, e); end
        tick(1);
        e = ev(0, 392, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL wall_clamp got=%h exp=%h", got, e); end
        tick(1);
        e = ev(2, 390, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL wall_rebound got=%h exp=%h", got, e); end
        tick(195);
        e = ev(392, 0, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL top_clamp got=%h exp=%h", got, e); end
        tick(1);
        e = ev(394, 2, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL top_rebound got=%h exp=%h", got, e); end
    endtask

    task automatic test_paddle_hit;
        tick(107);
        e = ev(608, 216, 208, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL pre_hit got=%h exp=%h", got, e); end
        tick(1);
        e = ev(608, 218, 208, 1, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL paddle_hit got=%h exp=%h", got, e); end
        tick(1);
        e = ev(606, 220, 208, 1, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL hit_rebound got=%h exp=%h", got, e); end
    endtask

    task automatic test_reset_mid_play;
        i_reset = 1'b0; i_frame_tick = 1'b1; i_down = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b1; i_frame_tick = 1'b0; i_down = 1'b0;
        e = ev(316, 236, 208, 0, 3, 0, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL reset_mid_play got=%h exp=%h", got, e); end
        @(negedge i_clock);
    endtask

    task automatic test_game_over;
        i_up = 1'b1; tick(1); tick(51);
        e = ev(316, 236, 4, 0, 3, 1, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL paddle_up_51 got=%h exp=%h", got, e); end
        tick(1);
        e = ev(316, 236, 0, 0, 3, 1, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL paddle_top_clamp got=%h exp=%h", got, e); end
        tick(8);
        e = ev(316, 236, 0, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL paddle_stays_0 got=%h exp=%h", got, e); end
        i_up = 1'b0; tick(463);
        e = ev(610, 218, 0, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL paddle_pass got=%h exp=%h", got, e); end
        tick(10);
        e = ev(630, 238, 0, 0, 3, 2, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL pre_miss got=%h exp=%h", got, e); end
        tick(1);
        e = ev(316, 236, 0, 0, 2, 1, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL miss1 got=%h exp=%h", got, e); end
        tick(534);
        e = ev(316, 236, 0, 0, 1, 1, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL miss2 got=%h exp=%h", got, e); end
        tick(534);
        e = ev(316, 236, 0, 0, 0, 3, 1); checks++;
        if (got !== e) begin failures++; $display("FAIL game_over got=%h exp=%h", got, e); end
        i_down = 1'b1; tick(3);
        checks++;
        if (got !== e) begin failures++; $display("FAIL over_frozen got=%h exp=%h", got, e); end
        i_up = 1'b1; tick(1);
        i_up = 1'b0; i_down = 1'b0;
        e = ev(316, 236, 208, 0, 3, 0, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL restart got=%h exp=%h", got, e); end
    endtask

    task automatic test_down_clamp;
        i_down = 1'b1; tick(1); tick(52);
        e = ev(316, 236, 416, 0, 3, 1, 0); checks++;
        if (got !== e) begin failures++; $display("FAIL paddle_bottom got=%h exp=%h", got, e); end
        tick(3);
        checks++;
        if (got !== e) begin failures++; $display("FAIL paddle_bottom_hold got=%h exp=%h", got, e); end
        i_down = 1'b0;
    endtask

    initial begin
        @(negedge i_clock);
        test_reset;
        test_idle;
        test_serve;
        test_bounce;
        test_paddle_hit;
        test_reset_mid_play;
        test_game_over;
        test_down_clamp;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
